// File: rtl/alu_pkg.sv
// Shared ALU control codes and the legality check for the 4-bit control field.
package alu_pkg;

   localparam logic [3:0] ALU_IDLE = 4'h0;
   localparam logic [3:0] ALU_ADD  = 4'h1;
   localparam logic [3:0] ALU_AND  = 4'h2;
   localparam logic [3:0] ALU_OR   = 4'h3;
   localparam logic [3:0] ALU_SUB  = 4'h4;
   localparam logic [3:0] ALU_XOR  = 4'h5;
   localparam logic [3:0] ALU_SLL  = 4'h6;
   localparam logic [3:0] ALU_EQ   = 4'h7;
   localparam logic [3:0] ALU_NE   = 4'h8;
   localparam logic [3:0] ALU_SRL  = 4'h9;
   localparam logic [3:0] ALU_LE   = 4'hA;
   localparam logic [3:0] ALU_LT   = 4'hB;
   localparam logic [3:0] ALU_SRA  = 4'hC;
   localparam logic [3:0] ALU_LUI  = 4'hD;

   // Codes 1..D are defined; 0 is idle and E/F are unassigned.
   function automatic logic alu_op_legal(input logic [3:0] op);
      return (op != ALU_IDLE) && (op <= ALU_LUI);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, searching upward mod NREQ.
module rr_arbiter #(
   parameter int NREQ = 2,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            anyGrant
);

   logic [IDW-1:0] cand;

   always_comb begin
      grant    = '0;
      idx      = '0;
      anyGrant = 1'b0;
      cand     = '0;
      for (int off = 0; off < NREQ; off++) begin
         cand = IDW'((int'(ptr) + off) % NREQ);
         if (en && !anyGrant && req[cand]) begin
            anyGrant    = 1'b1;
            idx         = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU with a one-entry response buffer.
// Optional ALU_ARB_OPCHK_EN: flag illegal control codes and suppress them at the ALU.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NREQ  = 2,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ*4-1:0] req_op,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WIDTH-1:0]  rsp_data,
   output logic [IDW-1:0]    rsp_id,
   output logic              rsp_err,
   output logic [WIDTH-1:0]  alu_srca,
   output logic [WIDTH-1:0]  alu_srcb,
   output logic [3:0]        alu_ctrl,
   input  logic [WIDTH-1:0]  alu_out
);

   logic             rspValidQ;
   logic [WIDTH-1:0] rspDataQ;
   logic [IDW-1:0]   rspIdQ;
   logic             rspErrQ;
   logic [IDW-1:0]   rrPtrQ;

   logic             canAccept;
   logic [NREQ-1:0]  grantVec;
   logic [IDW-1:0]   grantIdx;
   logic             anyGrant;
   logic [WIDTH-1:0] selA;
   logic [WIDTH-1:0] selB;
   logic [3:0]       selOp;
   logic             opLegal;
   logic [IDW-1:0]   nextPtr;

   // rst_n gates the enable so nothing is granted while reset is held.
   assign canAccept = (!rspValidQ || rsp_ready) && rst_n;

   rr_arbiter #(
      .NREQ(NREQ)
   ) u_rr (
      .req     (req_valid),
      .ptr     (rrPtrQ),
      .en      (canAccept),
      .grant   (grantVec),
      .idx     (grantIdx),
      .anyGrant(anyGrant)
   );

   assign req_ready = grantVec;
   assign selA  = req_a[int'(grantIdx)*WIDTH +: WIDTH];
   assign selB  = req_b[int'(grantIdx)*WIDTH +: WIDTH];
   assign selOp = req_op[int'(grantIdx)*4 +: 4];

`ifdef ALU_ARB_OPCHK_EN
   assign opLegal = alu_op_legal(selOp);
`else
   assign opLegal = 1'b1;
`endif

   assign alu_srca = anyGrant ? selA : '0;
   assign alu_srcb = anyGrant ? selB : '0;
   assign alu_ctrl = (anyGrant && opLegal) ? selOp : ALU_IDLE;

   assign nextPtr = (grantIdx == IDW'(NREQ - 1)) ? '0 : grantIdx + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rspValidQ <= 1'b0;
         rspDataQ  <= '0;
         rspIdQ    <= '0;
         rspErrQ   <= 1'b0;
         rrPtrQ    <= '0;
      end else if (anyGrant) begin
         rspValidQ <= 1'b1;
         rspDataQ  <= opLegal ? alu_out : '0;
         rspIdQ    <= grantIdx;
         rspErrQ   <= !opLegal;
         rrPtrQ    <= nextPtr;
      end else if (rsp_ready) begin
         rspValidQ <= 1'b0;
      end
   end

   assign rsp_valid = rspValidQ;
   assign rsp_data  = rspDataQ;
   assign rsp_id    = rspIdQ;
   assign rsp_err   = rspErrQ;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a reference ALU driving alu_out.
module tb_alu_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  reqValid;
   logic [1:0]  reqReady;
   logic [63:0] reqA;
   logic [63:0] reqB;
   logic [7:0]  reqOp;
   logic        rspValid;
   logic        rspReady;
   logic [31:0] rspData;
   logic [0:0]  rspId;
   logic        rspErr;
   logic [31:0] aluA;
   logic [31:0] aluB;
   logic [3:0]  aluCtrl;
   logic [31:0] aluOut;

   int nTests = 0;
   int nFail  = 0;

   alu_arbiter #(
      .WIDTH(32),
      .NREQ (2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(reqValid),
      .req_ready(reqReady),
      .req_a    (reqA),
      .req_b    (reqB),
      .req_op   (reqOp),
      .rsp_valid(rspValid),
      .rsp_ready(rspReady),
      .rsp_data (rspData),
      .rsp_id   (rspId),
      .rsp_err  (rspErr),
      .alu_srca (aluA),
      .alu_srcb (aluB),
      .alu_ctrl (aluCtrl),
      .alu_out  (aluOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Undefined codes yield a marker so pass-through of an illegal op is visible.
   always_comb begin
      case (aluCtrl)
         4'h1: aluOut = aluA + aluB;
         4'h2: aluOut = aluA & aluB;
         4'h3: aluOut = aluA | aluB;
         4'h4: aluOut = aluA - aluB;
         4'h5: aluOut = aluA ^ aluB;
         4'h6: aluOut = aluA << aluB[4:0];
         4'h7: aluOut = {31'b0, aluA == aluB};
         4'h8: aluOut = {31'b0, aluA != aluB};
         4'h9: aluOut = aluA >> aluB[4:0];
         4'hA: aluOut = {31'b0, $signed(aluA) <= $signed(aluB)};
         4'hB: aluOut = {31'b0, $signed(aluA) < $signed(aluB)};
         4'hC: aluOut = $signed(aluA) >>> aluB[4:0];
         4'hD: aluOut = {aluB[15:0], 16'b0};
         default: aluOut = 32'hDEADBEEF;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  valid;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [31:0] expData;
      logic        expErr;
      logic [3:0]  expCtrl;
   } vec_t;

   vec_t vecs[10];

   initial begin
      vecs[0] = '{2'b01, 32'd5,          32'd7,       4'h1, 32'd12,        1'b0, 4'h1};
      vecs[1] = '{2'b01, 32'd3,          32'd5,       4'h4, 32'hFFFFFFFE,  1'b0, 4'h4};
      vecs[2] = '{2'b10, 32'h80000000,   32'd4,       4'hC, 32'hF8000000,  1'b0, 4'hC};
      vecs[3] = '{2'b10, 32'd0,          32'h1234,    4'hD, 32'h12340000,  1'b0, 4'hD};
      vecs[4] = '{2'b10, 32'd3,          32'd9,       4'hB, 32'd1,         1'b0, 4'hB};
      vecs[5] = '{2'b01, 32'h0000F0F0,   32'h00000FF0, 4'h2, 32'h000000F0, 1'b0, 4'h2};
      vecs[6] = '{2'b10, 32'd1,          32'd4,       4'h6, 32'd16,        1'b0, 4'h6};
      vecs[7] = '{2'b01, 32'd5,          32'd5,       4'h7, 32'd1,         1'b0, 4'h7};
      vecs[8] = '{2'b10, 32'hFFFFFFFF,   32'd0,       4'hA, 32'd1,         1'b0, 4'hA};
`ifdef ALU_ARB_OPCHK_EN
      vecs[9] = '{2'b01, 32'd1,          32'd2,       4'hE, 32'd0,         1'b1, 4'h0};
`else
      vecs[9] = '{2'b01, 32'd1,          32'd2,       4'hE, 32'hDEADBEEF,  1'b0, 4'hE};
`endif

      rst_n    = 1'b0;
      reqValid = 2'b11;
      reqA     = '0;
      reqB     = '0;
      reqOp    = 8'h11;
      rspReady = 1'b1;

      // Reset state: nothing granted, ALU idle, buffer empty.
      @(negedge clk);
      #1;
      check("reset_req_ready", 32'(reqReady), 32'd0);
      check("reset_alu_ctrl", 32'(aluCtrl), 32'd0);
      check("reset_rsp_valid", 32'(rspValid), 32'd0);
      check("reset_rsp_data", rspData, 32'd0);

      // Contention from rr_ptr=0: grants alternate 0,1,0,1 with no bubbles.
      @(negedge clk);
      rst_n = 1'b1;
      reqA  = {32'd10, 32'd1};
      reqB  = {32'd10, 32'd1};
      for (int i = 0; i < 4; i++) begin
         #1;
         check("cont_req_ready", 32'(reqReady), (i % 2 == 0) ? 32'd1 : 32'd2);
         @(posedge clk);
         #1;
         check("cont_rsp_valid", 32'(rspValid), 32'd1);
         check("cont_rsp_id", 32'(rspId), 32'(i % 2));
         check("cont_rsp_data", rspData, (i % 2 == 0) ? 32'd2 : 32'd20);
         @(negedge clk);
      end

      // Single-requester vector table, back to back.
      for (int i = 0; i < 10; i++) begin
         reqValid = vecs[i].valid;
         reqA = '0;
         reqB = '0;
         reqOp = '0;
         if (vecs[i].valid[0]) begin
            reqA[31:0] = vecs[i].a;
            reqB[31:0] = vecs[i].b;
            reqOp[3:0] = vecs[i].op;
         end else begin
            reqA[63:32] = vecs[i].a;
            reqB[63:32] = vecs[i].b;
            reqOp[7:4]  = vecs[i].op;
         end
         #1;
         check($sformatf("vec%0d_req_ready", i), 32'(reqReady), 32'(vecs[i].valid));
         check($sformatf("vec%0d_alu_ctrl", i), 32'(aluCtrl), 32'(vecs[i].expCtrl));
         check($sformatf("vec%0d_alu_srca", i), aluA, vecs[i].a);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_rsp_valid", i), 32'(rspValid), 32'd1);
         check($sformatf("vec%0d_rsp_id", i), 32'(rspId), 32'(vecs[i].valid[1]));
         check($sformatf("vec%0d_rsp_data", i), rspData, vecs[i].expData);
         check($sformatf("vec%0d_rsp_err", i), 32'(rspErr), 32'(vecs[i].expErr));
         @(negedge clk);
      end

      // Drain with no new request empties the buffer.
      reqValid = 2'b00;
      @(posedge clk);
      #1;
      check("drain_rsp_valid", 32'(rspValid), 32'd0);

      // Backpressure: pending 3-5 result holds while rsp_ready is low.
      @(negedge clk);
      rspReady = 1'b0;
      reqValid = 2'b01;
      reqA     = {32'd2, 32'd3};
      reqB     = {32'd2, 32'd5};
      reqOp    = 8'h14;
      @(posedge clk);
      #1;
      check("bp_rsp_valid", 32'(rspValid), 32'd1);
      check("bp_rsp_data", rspData, 32'hFFFFFFFE);
      @(negedge clk);
      reqValid = 2'b10;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_req_ready", 32'(reqReady), 32'd0);
         @(posedge clk);
         #1;
         check("bp_hold_data", rspData, 32'hFFFFFFFE);
         check("bp_hold_id", 32'(rspId), 32'd0);
         @(negedge clk);
      end
      rspReady = 1'b1;
      #1;
      check("bp_release_ready", 32'(reqReady), 32'd2);
      @(posedge clk);
      #1;
      check("bp_release_id", 32'(rspId), 32'd1);
      check("bp_release_data", rspData, 32'd4);

      // Asynchronous reset with a stalled response pending.
      @(negedge clk);
      rspReady = 1'b0;
      reqValid = 2'b01;
      reqA     = {32'd0, 32'd5};
      reqB     = {32'd0, 32'd7};
      reqOp    = 8'h01;
      @(posedge clk);
      #1;
      check("rst_pre_valid", 32'(rspValid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_valid", 32'(rspValid), 32'd0);
      check("rst_async_data", rspData, 32'd0);
      @(negedge clk);
      reqValid = 2'b11;
      reqA     = {32'd1, 32'd1};
      reqB     = {32'd1, 32'd1};
      reqOp    = 8'h11;
      rspReady = 1'b1;
      rst_n    = 1'b1;
      #1;
      check("rst_first_ready", 32'(reqReady), 32'd1);
      @(posedge clk);
      #1;
      check("rst_first_id", 32'(rspId), 32'd0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer sharing one combinational ALU between NREQ execution requesters (e.g. main pipe, branch-compare unit, address generator). Each requester presents operands and a 4-bit ALU control code over a valid/ready handshake. The block grants one requester per cycle, drives the shared ALU's operand and control inputs, and captures the result, requester ID and error flag into a one-entry registered response buffer. It sits between the requesters and the execute-stage ALU.

## Interface
- WIDTH, 32, operand/result width
- NREQ, 2, number of requesters (2..8)
- IDW, $clog2(NREQ), width of requester ID
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_a  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B, same packing
- req_op  in  NREQ*4  ALU control code, requester i at [i*4 +: 4]
- rsp_valid  out  1  response buffer holds a result
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  WIDTH  ALU result
- rsp_id  out  IDW  index of requester that produced rsp_data
- rsp_err  out  1  illegal control code flag (see Configuration)
- alu_srca  out  WIDTH  to shared ALU operand A
- alu_srcb  out  WIDTH  to shared ALU operand B
- alu_ctrl  out  4  to shared ALU control
- alu_out  in  WIDTH  shared ALU result (combinational from alu_* outputs)

## Operation
- Legal control codes: 1 add, 2 and, 3 or, 4 sub, 5 xor, 6 sll, 7 eq, 8 ne, 9 srl, A le, B lt, C sra, D lui. Codes 0, E and F are illegal.
- can_accept = !rsp_valid || rsp_ready.
- Grant: if can_accept and any req_valid, grant the first valid requester at or after rr_ptr, searching upward mod NREQ. req_ready[g]=1 only for that requester; all other req_ready bits are 0.
- Granted requester's req_a, req_b and req_op drive alu_srca, alu_srcb and alu_ctrl in the same cycle. With no grant, alu_* are driven 0 (ctrl 0 = idle).
- On a grant edge: rsp_data<=alu_out, rsp_id<=g, rsp_err<=illegal(op), rsp_valid<=1, rr_ptr<=(g+1) mod NREQ.
- Response drained with no new grant: rsp_valid<=0 and data holds. Drain plus grant in the same cycle is a back-to-back replace with no bubble.
- rr_ptr is unchanged when nothing is granted.
- Requester rule: once req_valid is asserted, it and the operands/op stay stable until req_ready is seen. The block does not check this rule.
- Reset values: rsp_valid 0, rsp_data 0, rsp_id 0, rsp_err 0, rr_ptr 0. req_ready and alu_* are combinational and are 0 during reset.
- Reset mid-operation: any pending response is discarded. No grant occurs while rst_n is low.

## Timing
- Throughput is 1 op/cycle when rsp_ready is held at 1.
- Latency is 1 cycle: rsp_valid rises on the edge that accepts the request.
- req_valid->req_ready and req_*->alu_*->alu_out->rsp_data flop are combinational paths. The ALU sits fully inside this single cycle.
- rsp_valid stays asserted and rsp_* stay stable while rsp_ready=0. req_ready is 0 for all requesters during this time.
- Fairness: a continuously valid requester is granted within NREQ grants.

## Configuration
- ALU_ARB_OPCHK_EN defined: illegal codes (0, E, F) are still granted. The response has rsp_data=0 and rsp_err=1, and alu_ctrl is forced to 0 for that cycle.
- ALU_ARB_OPCHK_EN undefined: no decode. The code passes through to alu_ctrl unchanged, rsp_data=alu_out, and rsp_err is tied 0.

## Structure
- Shared package alu_pkg holds:
  - localparams for the 4-bit control codes (ALU_ADD=4'h1 … ALU_LUI=4'hD, ALU_IDLE=4'h0);
  - the function alu_op_legal(op).
- One sub-module, rr_arbiter (params NREQ):
  - inputs: req vector, ptr, enable;
  - outputs: one-hot grant, encoded index, any_grant;
  - purely combinational.
- The pointer register, response buffer and operand muxing live in alu_arbiter.

## Test plan
- Single request: requester 0, op=1, a=5, b=7, rsp_ready=1 -> req_ready[0]=1 same cycle. Next cycle rsp_valid=1, rsp_data=12, rsp_id=0, rsp_err=0.
- Contention: both valid continuously, rr_ptr=0 after reset, rsp_ready=1 -> grants alternate 0,1,0,1. rsp_id follows the same sequence with no idle cycles.
- Backpressure: rsp_ready=0 with a pending response (op=4, a=3, b=5) -> rsp_data holds 32'hFFFFFFFE and req_ready=0 for all requesters. Raising rsp_ready grants the next requester in the same cycle.
- Ops sweep on requester 1: op=C, a=32'h80000000, b=4 -> 32'hF8000000. Op=D, b=32'h1234 -> 32'h12340000. Op=B, a=3, b=9 -> 1.
- Illegal op=E with ALU_ARB_OPCHK_EN defined -> rsp_data=0, rsp_err=1. Without the macro -> rsp_err=0 and rsp_data=alu_out.
- Reset: assert rst_n=0 while rsp_valid=1 and rsp_ready=0 -> rsp_valid and rsp_data are 0 immediately (asynchronous). After release, the first grant goes to requester 0 when both are valid.
